// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron receive-side blocks: default widths,
// decoder state encoding and saturation constants.
package neuron_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned WIN_W_DEF = 16;
  localparam int unsigned ISI_W_DEF = 12;

  localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;
  localparam logic [ISI_W_DEF-1:0] ISI_SAT = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds whenever en is low.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr) begin
        cnt_d = '0;
      end else if (inc && (cnt_q != MAX)) begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike rising edges over a programmable window of enabled cycles,
// tracks the last inter-spike interval and hands results out over valid/ready.
module spike_rate_decoder
  import neuron_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned ISI_W = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] rate_count,
  output logic [ISI_W-1:0] isi_last,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_ctr_q, win_ctr_d;
  logic             spike_d_q;
  logic             isi_seen_q, isi_seen_d;
  logic [ISI_W-1:0] isi_reg_q, isi_reg_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] rate_count_q, rate_count_d;
  logic [ISI_W-1:0] isi_last_q, isi_last_d;
  logic             overrun_q, overrun_d;

  logic             spk_edge;
  logic             window_end;
  logic             spk_clr;
  logic             spk_inc;
  logic             load;
  logic [CNT_W-1:0] spk_cnt;
  logic [ISI_W-1:0] isi_cnt;
  logic [CNT_W-1:0] result;
  logic [ISI_W-1:0] isi_next;

  // spike_d_q tracks the line even while disabled so resuming never fakes an edge
  assign spk_edge   = spike_in & ~spike_d_q & ena;
  assign window_end = (state_q == COUNT) && ena && (win_ctr_q == (win_len_q - WIN_W'(1)));

  sat_counter #(.W(CNT_W)) u_spk_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .clr   (spk_clr),
    .inc   (spk_inc),
    .q     (spk_cnt)
  );

  sat_counter #(.W(ISI_W)) u_isi_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .clr   (spk_edge),
    .inc   (1'b1),
    .q     (isi_cnt)
  );

  always_comb begin
    result   = ((spk_cnt == CNT_MAX) || !spk_edge) ? spk_cnt : spk_cnt + CNT_W'(1);
    isi_next = (isi_cnt == ISI_MAX) ? isi_cnt : isi_cnt + ISI_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    win_len_d = win_len_q;
    win_ctr_d = win_ctr_q;
    spk_clr   = 1'b0;
    spk_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        spk_clr = 1'b1;
        if (ena && (window_len != '0)) begin
          state_d   = COUNT;
          win_len_d = window_len;
          win_ctr_d = '0;
        end
      end
      COUNT: begin
        spk_inc = spk_edge;
        if (window_end) begin
          spk_clr   = 1'b1;
          win_ctr_d = '0;
          win_len_d = window_len;
          state_d   = (window_len != '0) ? COUNT : IDLE;
        end else if (ena) begin
          win_ctr_d = win_ctr_q + WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    isi_seen_d = isi_seen_q;
    isi_reg_d  = isi_reg_q;
    if (spk_edge) begin
      isi_seen_d = 1'b1;
      if (isi_seen_q) begin
        isi_reg_d = isi_next;
      end
    end
  end

  // A result lands only if the slot is empty or being drained this same cycle
  always_comb begin
    load         = window_end && (!out_valid_q || out_ready);
    out_valid_d  = load || (out_valid_q && !out_ready);
    rate_count_d = rate_count_q;
    isi_last_d   = isi_last_q;
    overrun_d    = overrun_q;
    if (load) begin
      rate_count_d = result;
      isi_last_d   = isi_reg_q;
    end
    if (window_end && out_valid_q && !out_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      win_len_q    <= '0;
      win_ctr_q    <= '0;
      spike_d_q    <= 1'b0;
      isi_seen_q   <= 1'b0;
      isi_reg_q    <= '0;
      out_valid_q  <= 1'b0;
      rate_count_q <= '0;
      isi_last_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_len_q    <= win_len_d;
      win_ctr_q    <= win_ctr_d;
      spike_d_q    <= spike_in;
      isi_seen_q   <= isi_seen_d;
      isi_reg_q    <= isi_reg_d;
      out_valid_q  <= out_valid_d;
      rate_count_q <= rate_count_d;
      isi_last_q   <= isi_last_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign rate_count = rate_count_q;
  assign isi_last   = isi_last_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: table of single-window vectors plus
// hand-written sequences for saturation, backpressure, ena gaps and reset.
module tb_spike_rate_decoder;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        spike_in;
  logic [15:0] window_len;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  rate_count;
  logic [11:0] isi_last;
  logic        overrun;

  int n_tests;
  int n_fail;

  spike_rate_decoder #(.CNT_W(8), .WIN_W(16), .ISI_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .window_len (window_len),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .rate_count (rate_count),
    .isi_last   (isi_last),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] win;
    logic [15:0] pat;
    logic [7:0]  cnt;
    logic [11:0] isi;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic s);
    ena      = e;
    spike_in = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ena        = 1'b0;
    spike_in   = 1'b0;
    window_len = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // IDLE->COUNT takes one enabled cycle; counting starts on the next one
  task automatic start_win(input logic [15:0] w);
    window_len = w;
    ena        = 1'b1;
    spike_in   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    out_ready = 1'b1;

    vecs[0] = '{win: 16'd10, pat: 16'h0124, cnt: 8'd3, isi: 12'd3};
    vecs[1] = '{win: 16'd10, pat: 16'h00FC, cnt: 8'd1, isi: 12'd0};
    vecs[2] = '{win: 16'd1,  pat: 16'h0001, cnt: 8'd1, isi: 12'd0};
    vecs[3] = '{win: 16'd1,  pat: 16'h0000, cnt: 8'd0, isi: 12'd0};
    vecs[4] = '{win: 16'd12, pat: 16'h0051, cnt: 8'd3, isi: 12'd2};
    vecs[5] = '{win: 16'd8,  pat: 16'h00FF, cnt: 8'd1, isi: 12'd0};
    vecs[6] = '{win: 16'd8,  pat: 16'h0055, cnt: 8'd4, isi: 12'd2};
    vecs[7] = '{win: 16'd16, pat: 16'h8000, cnt: 8'd1, isi: 12'd0};
    vecs[8] = '{win: 16'd5,  pat: 16'h0009, cnt: 8'd2, isi: 12'd3};
    vecs[9] = '{win: 16'd16, pat: 16'h0000, cnt: 8'd0, isi: 12'd0};

    do_reset();
    chk("reset_valid", out_valid, 0);
    chk("reset_count", rate_count, 0);
    chk("reset_isi", isi_last, 0);
    chk("reset_overrun", overrun, 0);

    for (int v = 0; v < 10; v++) begin
      logic [15:0] pat;
      int          w;
      pat = vecs[v].pat;
      w   = int'(vecs[v].win);
      do_reset();
      out_ready = 1'b1;
      start_win(vecs[v].win);
      window_len = '0;
      for (int i = 0; i < w - 1; i++) cyc(1'b1, pat[i]);
      chk($sformatf("vec%0d_latency", v), out_valid, 0);
      cyc(1'b1, pat[w-1]);
      chk($sformatf("vec%0d_valid", v), out_valid, 1);
      chk($sformatf("vec%0d_count", v), rate_count, vecs[v].cnt);
      chk($sformatf("vec%0d_isi", v), isi_last, vecs[v].isi);
      chk($sformatf("vec%0d_overrun", v), overrun, 0);
      cyc(1'b1, 1'b0);
      chk($sformatf("vec%0d_drain", v), out_valid, 0);
    end

    // count saturation: 300 edges in a 600-cycle window
    do_reset();
    start_win(16'd600);
    window_len = '0;
    for (int i = 0; i < 599; i++) cyc(1'b1, (i % 2) == 0);
    chk("sat_latency", out_valid, 0);
    cyc(1'b1, 1'b0);
    chk("sat_valid", out_valid, 1);
    chk("sat_count", rate_count, 255);
    chk("sat_isi", isi_last, 2);

    // backpressure across two back-to-back windows
    begin
      logic [15:0] pat;
      pat = 16'h0051;
      do_reset();
      out_ready = 1'b0;
      start_win(16'd4);
      for (int k = 0; k < 8; k++) begin
        if (k == 4) window_len = '0;
        cyc(1'b1, pat[k]);
        if (k == 3) begin
          chk("bp_w1_valid", out_valid, 1);
          chk("bp_w1_count", rate_count, 1);
          chk("bp_w1_overrun", overrun, 0);
        end
      end
      chk("bp_held_valid", out_valid, 1);
      chk("bp_held_count", rate_count, 1);
      chk("bp_held_isi", isi_last, 0);
      chk("bp_overrun", overrun, 1);
      out_ready = 1'b1;
      cyc(1'b1, 1'b0);
      chk("bp_drain_valid", out_valid, 0);
      chk("bp_overrun_sticky", overrun, 1);
    end

    // window_len=1 with transfer and new result in the same cycle
    begin
      logic [3:0] pat;
      logic [3:0] exp_c;
      pat   = 4'b1101;
      exp_c = 4'b0101;
      do_reset();
      out_ready = 1'b1;
      start_win(16'd1);
      for (int k = 0; k < 4; k++) begin
        if (k == 3) window_len = '0;
        cyc(1'b1, pat[k]);
        chk($sformatf("w1_valid%0d", k), out_valid, 1);
        chk($sformatf("w1_count%0d", k), rate_count, {7'd0, exp_c[k]});
      end
      chk("w1_overrun", overrun, 0);
      cyc(1'b1, 1'b0);
      chk("w1_drain", out_valid, 0);
    end

    // ena gap of 5 cycles, spike rising during the gap is not an edge
    begin
      logic [12:0] ena_v;
      logic [12:0] spk_v;
      ena_v = 13'h1F07;
      spk_v = 13'h05F1;
      do_reset();
      out_ready = 1'b1;
      start_win(16'd8);
      window_len = '0;
      for (int k = 0; k < 12; k++) begin
        cyc(ena_v[k], spk_v[k]);
        chk($sformatf("ena_hold%0d", k), out_valid, 0);
      end
      cyc(ena_v[12], spk_v[12]);
      chk("ena_valid", out_valid, 1);
      chk("ena_count", rate_count, 2);
      chk("ena_isi", isi_last, 5);
    end

    // reset mid-window with a held result and a partly counted window
    begin
      logic [15:0] pat;
      pat = 16'h0055;
      do_reset();
      out_ready = 1'b0;
      start_win(16'd4);
      for (int k = 0; k < 7; k++) begin
        cyc(1'b1, pat[k]);
        if (k == 3) begin
          chk("rst_pre_valid", out_valid, 1);
          chk("rst_pre_count", rate_count, 2);
          chk("rst_pre_isi", isi_last, 2);
        end
      end
      rst_n = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_count", rate_count, 0);
      chk("rst_isi", isi_last, 0);
      chk("rst_overrun", overrun, 0);
      ena      = 1'b0;
      spike_in = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      pat = 16'h0102;
      start_win(16'd6);
      for (int k = 0; k < 12; k++) begin
        if (k == 6) window_len = '0;
        cyc(1'b1, pat[k]);
        if (k == 5) begin
          chk("post_a_valid", out_valid, 1);
          chk("post_a_count", rate_count, 1);
          chk("post_a_isi", isi_last, 0);
        end
      end
      chk("post_b_valid", out_valid, 1);
      chk("post_b_count", rate_count, 1);
      chk("post_b_isi", isi_last, 7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
